channel_mux: RTL and testbench
==============================

# channel_mux

Parameterised N-to-1 bus multiplexer used throughout the datapath (operand select, write-back select, PC source). It selects one `BUS_SIZE`-bit slice of a packed input bus by binary index and presents it combinationally. It also provides a registered copy and a registered select-error flag for pipeline-stage use.

## Interface
Parameters:
- `CHANNELS`, default 2: number of input channels, ≥2.
- `BUS_SIZE`, default `ARQUITECTURE_BITS` (32): width of each channel.

Ports:
- `clk`  input  1: clock; registered outputs update on the rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `enable`  input  1: when 1, registered outputs load on `clk`; when 0, they hold.
- `selector`  input  `CHANNELS`: binary channel index. The width equals `CHANNELS`, not log2.
- `data_in`  input  `CHANNELS*BUS_SIZE`: packed channels; channel k occupies bits `[BUS_SIZE*k +: BUS_SIZE]`.
- `data_out`  output  `BUS_SIZE`: combinational selected channel.
- `data_out_q`  output  `BUS_SIZE`: registered `data_out`.
- `sel_error_q`  output  1: registered out-of-range flag.

## Operation
- `data_out = data_in[BUS_SIZE*selector +: BUS_SIZE]` when `selector < CHANNELS`.
- `selector ≥ CHANNELS` (for example values 2–3 at CHANNELS=2, or 4–15 at CHANNELS=4):
  - `data_out = 0`.
  - The internal `sel_error` is 1.
- `sel_error = (selector ≥ CHANNELS)`; it is purely combinational.
- `data_out` is a pure function of `selector` and `data_in`:
  - no latches;
  - no dependence on `clk`, `reset_n` or `enable`.
- X or Z on `selector` need not be resolved. An implementation using full case with a zero default is acceptable.
- On a rising `clk` edge with `enable`=1:
  - `data_out_q` ← `data_out`;
  - `sel_error_q` ← `sel_error`.
- With `enable`=0, both registers hold their values.
- Reset (`reset_n`=0): `data_out_q` = 0 and `sel_error_q` = 0 immediately (asynchronous). They stay at 0 while reset is held.
- Reset has no effect on `data_out`.
- Arithmetic: the slice index is computed at width ≥ clog2(CHANNELS*BUS_SIZE)+1 so the out-of-range compare never overflows.

## Timing
- `data_out`: zero-cycle latency. It is valid within the same delta or settle time after `selector` or `data_in` change.
- `data_out_q` and `sel_error_q`: 1-cycle latency from the inputs sampled at the rising edge.
- Reset asserted mid-operation: the registers clear asynchronously. The first load occurs on the first rising edge after `reset_n` deasserts with `enable`=1.
- Simultaneous `selector` change and clock edge: the register captures the value that was settled before the edge. Standard setup rules apply; there is no special handling.

## Structure
- `ARQUITECTURE_BITS` (32) lives in the shared global definitions header or package used by all datapath blocks and benches.
- Single module, no sub-modules. The selection is a generate/for loop or an indexed part-select plus one output register process.
- Instances that need only the combinational path tie `enable` to 0 and leave `_q` outputs unconnected.

## Test plan
- CHANNELS=2, `data_in`={32'hDEADBEEF, 32'h12345678}, `selector`=0 then 1 → `data_out`=32'h12345678 then 32'hDEADBEEF after #10, with no clock toggling.
- CHANNELS=4, channels 0..3 = random words, `selector`=0,1,2,3 → each `data_out` is exactly equal (`!==` check) to `data_in[32*sel +: 32]`.
- CHANNELS=4, `selector`=4 and 15 → `data_out`=0; after one edge with `enable`=1, `sel_error_q`=1. Then `selector`=2 and one edge → `sel_error_q`=0.
- Registered path: `enable`=1, `selector`=1 with channel 1 = 32'hA5A5A5A5 → `data_out_q` equals it one rising edge later. Set `enable`=0 and change `selector` → `data_out_q` holds.
- Drop `reset_n` to 0 between clock edges while `data_out_q`≠0 → `data_out_q`=0 and `sel_error_q`=0 immediately, while `data_out` still tracks `selector`.

Source files
------------

// File: rtl/channel_mux_pkg.sv
// Shared datapath definitions used by the channel mux and its bench.
package channel_mux_pkg;

  // Native datapath word width.
  localparam int ARQUITECTURE_BITS = 32;

endpackage : channel_mux_pkg

// File: rtl/channel_mux.sv
// N-to-1 bus multiplexer: combinational select by binary index,
// plus a registered copy and a registered out-of-range flag.
module channel_mux
  import channel_mux_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int BUS_SIZE = ARQUITECTURE_BITS
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [CHANNELS-1:0]          selector,
  input  logic [CHANNELS*BUS_SIZE-1:0] data_in,
  output logic [BUS_SIZE-1:0]          data_out,
  output logic [BUS_SIZE-1:0]          data_out_q,
  output logic                         sel_error_q
);

  logic sel_hit;
  logic sel_error;

  // Select the matching channel. Each channel is compared for equality
  // against the selector at the selector's own width, so no index
  // arithmetic is needed and the range test cannot overflow. An
  // unmatched selector leaves the zero default and flags an error.
  always_comb begin
    data_out = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (selector == CHANNELS'(k)) begin
        data_out = data_in[k*BUS_SIZE +: BUS_SIZE];
        sel_hit  = 1'b1;
      end
    end
    sel_error = ~sel_hit;
  end

  // Pipeline-stage copy: load on enable, hold otherwise, clear on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q  <= '0;
      sel_error_q <= 1'b0;
    end else if (enable) begin
      data_out_q  <= data_out;
      sel_error_q <= sel_error;
    end
  end

endmodule : channel_mux

// File: tb/tb_channel_mux.sv
// Directed bench for channel_mux at CHANNELS=2 and CHANNELS=4.
module tb_channel_mux;
  import channel_mux_pkg::*;

  localparam int W = ARQUITECTURE_BITS;

  logic            clk;
  logic            reset_n;
  logic            enable;

  logic [1:0]      sel2;
  logic [2*W-1:0]  din2;
  logic [W-1:0]    dout2, dout2_q;
  logic            err2_q;

  logic [3:0]      sel4;
  logic [4*W-1:0]  din4;
  logic [W-1:0]    dout4, dout4_q;
  logic            err4_q;

  int checks = 0;
  int errors = 0;

  localparam logic [W-1:0] W0 = 32'h0BADF00D;
  localparam logic [W-1:0] W1 = 32'hA5A5A5A5;
  localparam logic [W-1:0] W2 = 32'hCAFEBABE;
  localparam logic [W-1:0] W3 = 32'h76543210;

  channel_mux #(.CHANNELS(2), .BUS_SIZE(W)) u_mux2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .selector   (sel2),
    .data_in    (din2),
    .data_out   (dout2),
    .data_out_q (dout2_q),
    .sel_error_q(err2_q)
  );

  channel_mux #(.CHANNELS(4), .BUS_SIZE(W)) u_mux4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .selector   (sel4),
    .data_in    (din4),
    .data_out   (dout4),
    .data_out_q (dout4_q),
    .sel_error_q(err4_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare and tally
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // step past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset_n = 1'b1;
    enable  = 1'b0;
    sel2    = '0;
    din2    = {32'hDEADBEEF, 32'h12345678};
    sel4    = '0;
    din4    = {W3, W2, W1, W0};
    #2 reset_n = 1'b0;
    #1;
    chk("rst_q2",   dout2_q, '0);
    chk("rst_err2", {31'd0, err2_q}, '0);
    chk("rst_q4",   dout4_q, '0);
    chk("rst_err4", {31'd0, err4_q}, '0);

    // 2-channel combinational select, reset still held
    sel2 = 2'd0; #10;
    chk("c2_sel0", dout2, 32'h12345678);
    sel2 = 2'd1; #10;
    chk("c2_sel1", dout2, 32'hDEADBEEF);
    sel2 = 2'd2; #1;
    chk("c2_sel2", dout2, '0);
    sel2 = 2'd3; #1;
    chk("c2_sel3", dout2, '0);

    // 4-channel combinational select, every index
    sel4 = 4'd0; #1; chk("c4_sel0", dout4, W0);
    sel4 = 4'd1; #1; chk("c4_sel1", dout4, W1);
    sel4 = 4'd2; #1; chk("c4_sel2", dout4, W2);
    sel4 = 4'd3; #1; chk("c4_sel3", dout4, W3);

    // release reset, out-of-range select
    tick();
    reset_n = 1'b1;
    enable  = 1'b1;
    sel4    = 4'd4;
    #1 chk("c4_sel4", dout4, '0);
    tick();
    chk("err_sel4",  {31'd0, err4_q}, 32'd1);
    chk("q_sel4",    dout4_q, '0);
    sel4 = 4'd15;
    #1 chk("c4_sel15", dout4, '0);
    tick();
    chk("err_sel15", {31'd0, err4_q}, 32'd1);
    sel4 = 4'd2;
    tick();
    chk("err_clr",   {31'd0, err4_q}, '0);
    chk("q_sel2",    dout4_q, W2);

    // registered path with enable hold
    sel4 = 4'd1;
    tick();
    chk("q_sel1", dout4_q, W1);
    enable = 1'b0;
    sel4   = 4'd3;
    tick();
    chk("hold_q",   dout4_q, W1);
    chk("hold_comb", dout4, W3);
    sel4 = 4'd9;
    tick();
    chk("hold_err", {31'd0, err4_q}, '0);
    chk("hold_q2",  dout4_q, W1);

    // asynchronous reset between edges
    enable = 1'b1;
    sel4   = 4'd1;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_q",   dout4_q, '0);
    chk("arst_err", {31'd0, err4_q}, '0);
    sel4 = 4'd0;
    #1 chk("arst_comb", dout4, W0);
    tick();
    chk("arst_hold", dout4_q, '0);

    // first load after release
    reset_n = 1'b1;
    sel4    = 4'd3;
    tick();
    chk("rel_q", dout4_q, W3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_channel_mux
